led_code_seq: RTL

Status-code sequencer that drives an LED blinker stage's `ena` / `off` / `on` configuration inputs. It observes the blinker's LED output and gates it so the LED emits exactly N blinks, then a dark gap, then repeats, where N is a programmable status code. It sits between the bootloader control logic, which posts status codes, and the blinker.

---
 rtl/led_code_seq_if.sv | 25 ++
 rtl/led_code_seq.sv | 114 +++++++++++
 2 files changed

// File: rtl/led_code_seq_if.sv
// Connection bundle between the status-code sequencer, its host and the LED blinker.
// The master side posts codes and returns the blinker LED; the slave side is the sequencer.
interface led_code_seq_if #(
    parameter int TW = 11,
    parameter int CW = 4
);
    logic [CW-1:0] code;
    logic          code_stb;
    logic          blk_led;
    logic          blk_ena;
    logic [TW-1:0] blk_off;
    logic [TW-1:0] blk_on;
    logic          busy;
    logic          seq_done;

    modport master (
        output code, code_stb, blk_led,
        input  blk_ena, blk_off, blk_on, busy, seq_done
    );

    modport slave (
        input  code, code_stb, blk_led,
        output blk_ena, blk_off, blk_on, busy, seq_done
    );
endinterface

// File: rtl/led_code_seq.sv
// Status-code sequencer: gates an LED blinker so it emits N blinks, a dark gap, then repeats.
//   state   | meaning
//   S_IDLE  | blinker disabled, waiting for a nonzero pending code
//   S_BLINK | blinker enabled, counting LED falling edges down to the end of the burst
//   S_GAP   | blinker disabled for GAP_CYC cycles before the next burst or idle
module led_code_seq #(
    parameter int              TW      = 11,
    parameter int              CW      = 4,
    parameter int              GW      = 24,
    parameter logic [TW-1:0]   ON_VAL  = 11'h600,
    parameter logic [TW-1:0]   OFF_VAL = 11'h600,
    parameter logic [GW-1:0]   GAP_CYC = 24'd6000000
) (
    input  logic           clk,
    input  logic           rst_n,
    led_code_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLINK = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [GW-1:0] GAP_LOAD = GAP_CYC - 1'b1;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_pend;
    logic [CW-1:0] r_cur;
    logic [CW-1:0] r_cnt;
    logic [GW-1:0] r_gap;
    logic          r_led_d;
    logic          r_seq_done;
    logic [CW-1:0] w_cur_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [GW-1:0] w_gap_nxt;
    logic          w_seq_done_nxt;
    logic          w_fall;

    assign w_fall = r_led_d & ~bus.blk_led;

    always_comb begin
        w_state_nxt    = r_state;
        w_cur_nxt      = r_cur;
        w_cnt_nxt      = r_cnt;
        w_gap_nxt      = r_gap;
        w_seq_done_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pend != '0) begin
                    w_cur_nxt   = r_pend;
                    w_cnt_nxt   = r_pend;
                    w_state_nxt = S_BLINK;
                end
            end
            S_BLINK: begin
                if (w_fall) begin
                    if (r_cnt == CW'(1)) begin
                        w_seq_done_nxt = 1'b1;
                        w_gap_nxt      = GAP_LOAD;
                        w_state_nxt    = S_GAP;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
            end
            S_GAP: begin
                // A code posted during the burst or gap is picked up only here, at the boundary.
                if (r_gap == '0) begin
                    if (r_pend != '0) begin
                        w_cur_nxt   = r_pend;
                        w_cnt_nxt   = r_pend;
                        w_state_nxt = S_BLINK;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_gap_nxt = r_gap - 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pend     <= '0;
            r_cur      <= '0;
            r_cnt      <= '0;
            r_gap      <= '0;
            r_led_d    <= 1'b0;
            r_seq_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur      <= w_cur_nxt;
            r_cnt      <= w_cnt_nxt;
            r_gap      <= w_gap_nxt;
            r_led_d    <= bus.blk_led;
            r_seq_done <= w_seq_done_nxt;
            if (bus.code_stb) begin
                r_pend <= bus.code;
            end
        end
    end

    assign bus.blk_ena  = (r_state == S_BLINK);
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.seq_done = r_seq_done;
    assign bus.blk_off  = OFF_VAL;
    assign bus.blk_on   = ON_VAL;

endmodule
